// File: rtl/sched_pkg.sv
// sched_pkg: shared types and constants for the request scheduler
package sched_pkg;
    localparam int NUM_CH = 4;
    localparam int DEF_AGE_LIMIT = 8;
    typedef enum logic {SCHED_IDLE, SCHED_GRANT} sched_state_e;
endpackage

// File: rtl/prio_sel4.sv
// prio_sel4: fixed-priority one-hot select, bit 3 highest, all zero when disabled
module prio_sel4
    import sched_pkg::*;
(
    input  logic              en,
    input  logic [NUM_CH-1:0] vec,
    output logic [NUM_CH-1:0] sel
);
    always_comb begin
        sel = !en   ? 4'b0000 :
              vec[3] ? 4'b1000 :
              vec[2] ? 4'b0100 :
              vec[1] ? 4'b0010 :
              vec[0] ? 4'b0001 : 4'b0000;
    end
endmodule

// File: rtl/req_sched4.sv
// req_sched4: four-channel request scheduler with held one-hot grants and
// age-based promotion so low-priority requesters cannot starve
module req_sched4
    import sched_pkg::*;
#(
    parameter int AGE_LIMIT = DEF_AGE_LIMIT,
    localparam int AGE_W = $clog2(AGE_LIMIT + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              en,
    input  logic [NUM_CH-1:0] req_pulse,
    input  logic              done,
    output logic [NUM_CH-1:0] gnt,
    output logic [NUM_CH-1:0] pending,
    output logic [NUM_CH-1:0] aged,
    output logic              busy
);
    sched_state_e      state_q, state_d;
    logic [NUM_CH-1:0] gnt_q, gnt_d, pending_q, pending_d, sel_vec, issue_sel;
    logic              issue;

    // A new grant may be issued from IDLE or on the same edge the holder finishes
    assign issue = en && |pending_q && (state_q == SCHED_IDLE || done);
    assign sel_vec = |aged ? aged : pending_q;

    prio_sel4 u_sel (
        .en  (issue),
        .vec (sel_vec),
        .sel (issue_sel)
    );

    always_comb begin
        pending_d = (pending_q & ~issue_sel) | req_pulse;
        state_d   = (issue || (state_q == SCHED_GRANT && !done)) ? SCHED_GRANT : SCHED_IDLE;
        gnt_d     = issue ? issue_sel : (state_d == SCHED_GRANT) ? gnt_q : '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= SCHED_IDLE;
            gnt_q     <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            pending_q <= pending_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_age
        logic [AGE_W-1:0] age_q, age_d;
        always_comb begin
            age_d = (!pending_q[i] || issue_sel[i]) ? '0 :
                    (age_q == AGE_W'(AGE_LIMIT)) ? age_q : age_q + 1'b1;
        end
        always_ff @(posedge clock) begin
            if (reset) age_q <= '0;
            else       age_q <= age_d;
        end
        assign aged[i] = pending_q[i] && (age_q == AGE_W'(AGE_LIMIT));
    end

    assign gnt     = gnt_q;
    assign pending = pending_q;
    assign busy    = (state_q == SCHED_GRANT);
endmodule

// File: tb/tb_req_sched4.sv
// tb_req_sched4: scoreboard bench for req_sched4 against a per-channel
// request/wait-time model, directed scenarios followed by random traffic
module tb_req_sched4;
    localparam int LIM = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       done = 1'b0;
    logic [3:0] req_pulse = 4'b0000;
    logic [3:0] gnt, pending, aged;
    logic       busy;

    always #5 clock = ~clock;

    req_sched4 #(.AGE_LIMIT(LIM)) dut (
        .clock     (clock),
        .reset     (reset),
        .en        (en),
        .req_pulse (req_pulse),
        .done      (done),
        .gnt       (gnt),
        .pending   (pending),
        .aged      (aged),
        .busy      (busy)
    );

    typedef struct packed {
        logic [3:0] gnt;
        logic [3:0] pend;
        logic [3:0] aged;
        logic       busy;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Model: which channel holds the grant, which have a request waiting,
    // and how many cycles each waiting request has been waiting (capped).
    int m_holder = -1;
    bit m_wait[4];
    int m_waited[4];

    task automatic chk(input string nm, input logic [3:0] got, input logic [3:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %b want %b", nm, got, want);
        end
    endtask

    task automatic step(input bit r, input bit e, input logic [3:0] p, input bit d);
        int   winner;
        bit   any_wait, any_old;
        exp_t x;
        reset = r; en = e; req_pulse = p; done = d;
        winner = -1; any_wait = 0; any_old = 0;
        for (int i = 0; i < 4; i++) begin
            if (m_wait[i]) any_wait = 1;
            if (m_wait[i] && m_waited[i] == LIM) any_old = 1;
        end
        // Ascending scan leaves the highest-numbered eligible channel in winner
        if (!r && e && any_wait && (m_holder < 0 || d))
            for (int i = 0; i < 4; i++)
                if (m_wait[i] && (!any_old || m_waited[i] == LIM)) winner = i;
        if (r) begin
            m_holder = -1;
            for (int i = 0; i < 4; i++) begin m_wait[i] = 0; m_waited[i] = 0; end
        end else begin
            for (int i = 0; i < 4; i++) begin
                m_waited[i] = (!m_wait[i] || winner == i) ? 0 :
                              (m_waited[i] >= LIM ? LIM : m_waited[i] + 1);
                m_wait[i] = (m_wait[i] && winner != i) || p[i];
            end
            if (winner >= 0) m_holder = winner;
            else if (d) m_holder = -1;
        end
        x.gnt  = (m_holder < 0) ? 4'b0000 : 4'(1 << m_holder);
        x.busy = (m_holder >= 0);
        for (int i = 0; i < 4; i++) begin
            x.pend[i] = m_wait[i];
            x.aged[i] = m_wait[i] && m_waited[i] == LIM;
        end
        @(posedge clock);
        #1;
        exp_q.push_back(x);
    endtask

    // Monitor: outputs are valid every cycle; compare each against its expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({gnt, pending, aged, busy} !== e) begin
                    n_err++;
                    $display("FAIL cycle: got gnt=%b pend=%b aged=%b busy=%b want gnt=%b pend=%b aged=%b busy=%b",
                             gnt, pending, aged, busy, e.gnt, e.pend, e.aged, e.busy);
                end
            end
        end
    end

    initial begin
        @(posedge clock);
        #1;
        step(1, 0, 4'b0000, 0);
        step(1, 0, 4'b0000, 0);
        chk("reset_gnt", gnt, 4'b0000);
        chk("reset_busy", {3'b000, busy}, 4'b0000);

        // Minimum latency, then release
        step(0, 1, 4'b0100, 0);
        chk("lat_pending", pending, 4'b0100);
        step(0, 1, 4'b0000, 0);
        chk("lat_gnt", gnt, 4'b0100);
        chk("lat_busy", {3'b000, busy}, 4'b0001);
        step(0, 1, 4'b0000, 0);
        step(0, 1, 4'b0000, 1);
        chk("release_gnt", gnt, 4'b0000);

        // Back-to-back priority order
        step(0, 1, 4'b1011, 0);
        step(0, 1, 4'b0000, 0);
        chk("b2b_first", gnt, 4'b1000);
        step(0, 1, 4'b0000, 1);
        chk("b2b_second", gnt, 4'b0010);
        step(0, 1, 4'b0000, 1);
        chk("b2b_third", gnt, 4'b0001);
        step(0, 1, 4'b0000, 1);
        chk("b2b_end", gnt, 4'b0000);

        // Aging: channel 0 waits behind a held channel 3 and overtakes channel 2
        step(0, 1, 4'b1000, 0);
        step(0, 1, 4'b0001, 0);
        chk("age_hold", gnt, 4'b1000);
        step(0, 1, 4'b0100, 0);
        for (int k = 0; k < LIM - 1; k++) step(0, 1, 4'b0000, 0);
        chk("age_aged", aged, 4'b0001);
        chk("age_pending", pending, 4'b0101);
        step(0, 1, 4'b0000, 1);
        chk("age_winner", gnt, 4'b0001);
        step(0, 1, 4'b0000, 1);
        step(0, 1, 4'b0000, 1);

        // Enable gating and hold while disabled
        step(0, 0, 4'b0110, 0);
        step(0, 0, 4'b0000, 0);
        chk("en_low_gnt", gnt, 4'b0000);
        chk("en_low_pend", pending, 4'b0110);
        step(0, 1, 4'b0000, 0);
        chk("en_high_gnt", gnt, 4'b0100);
        step(0, 0, 4'b0000, 0);
        step(0, 0, 4'b0000, 0);
        chk("en_drop_held", gnt, 4'b0100);
        step(0, 0, 4'b0000, 1);
        chk("en_drop_done", gnt, 4'b0000);
        step(0, 1, 4'b0000, 0);
        step(0, 1, 4'b0000, 1);

        // Re-request on the channel being granted
        step(0, 1, 4'b0010, 0);
        step(0, 1, 4'b0010, 0);
        chk("rereq_gnt", gnt, 4'b0010);
        chk("rereq_pend", pending, 4'b0010);
        step(0, 1, 4'b0000, 1);
        chk("rereq_again", gnt, 4'b0010);
        step(0, 1, 4'b0000, 1);

        // Reset mid-grant, then done while idle
        step(0, 1, 4'b1000, 0);
        step(0, 1, 4'b0011, 0);
        chk("pre_rst_pend", pending, 4'b0011);
        step(1, 1, 4'b0000, 0);
        chk("rst_gnt", gnt, 4'b0000);
        chk("rst_pend", pending, 4'b0000);
        step(0, 1, 4'b0000, 1);
        chk("idle_done", {gnt, pending}, 8'h00);

        // Random traffic
        for (int k = 0; k < 500; k++)
            step($urandom_range(63) == 0, $urandom_range(7) != 0,
                 ($urandom_range(2) == 0) ? 4'($urandom) : 4'b0000,
                 $urandom_range(2) == 0);

        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clock);
        #1;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: got %0d left want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
